// File: rtl/instruction_loader.sv
// Assembles a big-endian byte stream into words and writes them to instruction memory.
// Latency: the write strobe is registered and appears 1 cycle after the last byte of each word.
// Backpressure: none; a byte arriving during the WRITE cycle is kept as the next word's first byte.
module instruction_loader #(
    parameter int                   BITS_SIZE  = 32,
    parameter int                   SIZE_TOTAL = 256,
    parameter int                   BYTE_SIZE  = 8,
    parameter logic [BITS_SIZE-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [BYTE_SIZE-1:0] i_rx_data,
    input  logic                 i_rx_done,
    output logic [BITS_SIZE-1:0] o_instruction_address,
    output logic [BITS_SIZE-1:0] o_instruction,
    output logic                 o_flag_write_intruc,
    output logic                 o_busy,
    output logic                 o_load_done,
    output logic                 o_overflow,
    output logic [BITS_SIZE-1:0] o_word_count
);

    localparam int BYTES = BITS_SIZE / BYTE_SIZE;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BITS_SIZE-1:0] LAST_ADDR = BITS_SIZE'(SIZE_TOTAL - BYTES);
    localparam logic [BITS_SIZE-1:0] ADDR_STEP = BITS_SIZE'(BYTES);
    localparam logic [CNT_W-1:0]     LAST_BYTE = CNT_W'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     byte_cnt;
    logic [BITS_SIZE-1:0] shift_reg;
    logic [BITS_SIZE-1:0] shifted;

    assign shifted = {shift_reg[BITS_SIZE-BYTE_SIZE-1:0], i_rx_data};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state                 <= IDLE;
            byte_cnt              <= '0;
            shift_reg             <= '0;
            o_instruction_address <= '0;
            o_instruction         <= '0;
            o_word_count          <= '0;
            o_flag_write_intruc   <= 1'b0;
            o_busy                <= 1'b0;
            o_load_done           <= 1'b0;
            o_overflow            <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        state                 <= RECEIVE;
                        byte_cnt              <= '0;
                        o_instruction_address <= '0;
                        o_word_count          <= '0;
                        o_busy                <= 1'b1;
                        o_load_done           <= 1'b0;
                        o_overflow            <= 1'b0;
                    end
                end
                RECEIVE: begin
                    if (i_rx_done) begin
                        shift_reg <= shifted;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt            <= '0;
                            o_instruction       <= shifted;
                            o_flag_write_intruc <= 1'b1;
                            state               <= WRITE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    o_flag_write_intruc <= 1'b0;
                    o_word_count        <= o_word_count + BITS_SIZE'(1);
                    if (o_instruction == HALT_WORD) begin
                        state       <= DONE;
                        o_busy      <= 1'b0;
                        o_load_done <= 1'b1;
                    end else if (o_instruction_address == LAST_ADDR) begin
                        state       <= DONE;
                        o_busy      <= 1'b0;
                        o_load_done <= 1'b1;
                        o_overflow  <= 1'b1;
                    end else begin
                        state                 <= RECEIVE;
                        o_instruction_address <= o_instruction_address + ADDR_STEP;
                        // A byte landing in this cycle opens the next word.
                        if (i_rx_done) begin
                            shift_reg <= shifted;
                            byte_cnt  <= CNT_W'(1);
                        end else begin
                            byte_cnt <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_done = 1'b0;
    logic [31:0] o_instruction_address;
    logic [31:0] o_instruction;
    logic        o_flag_write_intruc;
    logic        o_busy;
    logic        o_load_done;
    logic        o_overflow;
    logic [31:0] o_word_count;

    int n_checks = 0;
    int n_errors = 0;
    int b2b_cnt  = 0;
    logic prev_flag = 1'b0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_dat_q[$];

    instruction_loader dut (
        .i_clk                 (i_clk),
        .i_reset               (i_reset),
        .i_start               (i_start),
        .i_rx_data             (i_rx_data),
        .i_rx_done             (i_rx_done),
        .o_instruction_address (o_instruction_address),
        .o_instruction         (o_instruction),
        .o_flag_write_intruc   (o_flag_write_intruc),
        .o_busy                (o_busy),
        .o_load_done           (o_load_done),
        .o_overflow            (o_overflow),
        .o_word_count          (o_word_count)
    );

    always #5 i_clk = ~i_clk;

    // Write-port monitor, sampled away from the active edge.
    always @(negedge i_clk) begin
        if (o_flag_write_intruc) begin
            wr_addr_q.push_back(o_instruction_address);
            wr_dat_q.push_back(o_instruction);
            if (prev_flag) b2b_cnt++;
        end
        prev_flag = o_flag_write_intruc;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clk);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge i_clk);
        i_rx_done = 1'b0;
    endtask

    // Bytes on consecutive cycles, no gaps.
    task automatic send_burst(input logic [7:0] bytes[$]);
        foreach (bytes[i]) begin
            @(negedge i_clk);
            i_rx_data = bytes[i];
            i_rx_done = 1'b1;
        end
        @(negedge i_clk);
        i_rx_done = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!o_load_done && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        check({tag, "_done"}, {31'b0, o_load_done}, 32'd1);
    endtask

    task automatic clear_q();
        wr_addr_q.delete();
        wr_dat_q.delete();
    endtask

    initial begin
        logic [7:0] bq[$];

        repeat (3) @(negedge i_clk);
        check("rst_addr",  o_instruction_address, 32'd0);
        check("rst_instr", o_instruction, 32'd0);
        check("rst_wc",    o_word_count, 32'd0);
        check("rst_flags", {28'b0, o_flag_write_intruc, o_busy, o_load_done, o_overflow}, 32'd0);
        i_reset = 1'b0;

        // Bytes without start: nothing written.
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        repeat (3) @(negedge i_clk);
        check("nostart_writes", wr_addr_q.size(), 32'd0);
        check("nostart_busy", {31'b0, o_busy}, 32'd0);

        // Basic program with halt.
        pulse_start();
        check("start_busy", {31'b0, o_busy}, 32'd1);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
        wait_done("basic");
        check("basic_nwr", wr_addr_q.size(), 32'd2);
        if (wr_addr_q.size() == 2) begin
            check("basic_a0", wr_addr_q[0], 32'd0);
            check("basic_d0", wr_dat_q[0], 32'h2008_0005);
            check("basic_a1", wr_addr_q[1], 32'd4);
            check("basic_d1", wr_dat_q[1], 32'hFFFF_FFFF);
        end
        check("basic_ovf", {31'b0, o_overflow}, 32'd0);
        check("basic_wc", o_word_count, 32'd2);
        check("basic_busy", {31'b0, o_busy}, 32'd0);

        // Bytes after DONE are ignored and outputs hold.
        clear_q();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        repeat (3) @(negedge i_clk);
        check("after_done_nwr", wr_addr_q.size(), 32'd0);
        check("after_done_hold", {31'b0, o_load_done}, 32'd1);
        check("after_done_wc", o_word_count, 32'd2);

        // Restart: strobe timing with exact cycle sampling.
        pulse_start();
        check("restart_addr", o_instruction_address, 32'd0);
        check("restart_wc", o_word_count, 32'd0);
        check("restart_done", {31'b0, o_load_done}, 32'd0);
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
        @(negedge i_clk);
        i_rx_data = 8'hD4;
        i_rx_done = 1'b1;
        @(negedge i_clk);
        i_rx_done = 1'b0;
        check("lat_strobe", {31'b0, o_flag_write_intruc}, 32'd1);
        check("lat_addr", o_instruction_address, 32'd0);
        check("lat_data", o_instruction, 32'hA1B2_C3D4);
        @(negedge i_clk);
        check("lat_width", {31'b0, o_flag_write_intruc}, 32'd0);
        check("lat_wc", o_word_count, 32'd1);

        // Byte during WRITE is byte 0 of the next word; bytes every cycle.
        clear_q();
        bq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_burst(bq);
        wait_done("wrbyte");
        check("wrbyte_nwr", wr_addr_q.size(), 32'd3);
        if (wr_addr_q.size() == 3) begin
            check("wrbyte_d0", wr_dat_q[0], 32'h1234_5678);
            check("wrbyte_a0", wr_addr_q[0], 32'd4);
            check("wrbyte_d1", wr_dat_q[1], 32'hAABB_CCDD);
            check("wrbyte_a1", wr_addr_q[1], 32'd8);
            check("wrbyte_d2", wr_dat_q[2], 32'hFFFF_FFFF);
            check("wrbyte_a2", wr_addr_q[2], 32'd12);
        end
        check("wrbyte_wc", o_word_count, 32'd4);

        // Reset mid-word abandons the partial word.
        pulse_start();
        clear_q();
        send_byte(8'h99); send_byte(8'h88);
        @(negedge i_clk);
        i_reset = 1'b1;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check("midrst_busy", {31'b0, o_busy}, 32'd0);
        i_reset = 1'b0;
        pulse_start();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        repeat (2) @(negedge i_clk);
        check("midrst_nwr", wr_addr_q.size(), 32'd1);
        if (wr_addr_q.size() == 1) begin
            check("midrst_a0", wr_addr_q[0], 32'd0);
            check("midrst_d0", wr_dat_q[0], 32'h1122_3344);
        end
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
        wait_done("midrst");

        // Fill all 64 words without a halt.
        pulse_start();
        clear_q();
        for (int k = 0; k < 64; k++) begin
            bq = '{8'h00, 8'h00, 8'h00, 8'(k)};
            send_burst(bq);
        end
        wait_done("ovf");
        check("ovf_nwr", wr_addr_q.size(), 32'd64);
        if (wr_addr_q.size() == 64) begin
            check("ovf_alast", wr_addr_q[63], 32'd252);
            check("ovf_dlast", wr_dat_q[63], 32'h0000_003F);
            check("ovf_a1", wr_addr_q[1], 32'd4);
        end
        check("ovf_flag", {31'b0, o_overflow}, 32'd1);
        check("ovf_wc", o_word_count, 32'd64);
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_burst(bq);
        repeat (3) @(negedge i_clk);
        check("ovf_no65", wr_addr_q.size(), 32'd64);
        check("ovf_addr_hold", o_instruction_address, 32'd252);

        check("no_b2b", b2b_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
